instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time program loader that writes instruction memory from a byte stream and holds the CPU in reset until the program is resident. It sits between an external byte source (UART receiver, debug link, or testbench driver) and the write port of instruction memory. The CPU fetches from that memory through its read port. The loader gates the CPU's `resetn` so the first fetch sees the complete program.

## Interface
- `DEPTH`, default 1024: instruction memory capacity in 32-bit words; the largest legal word count.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of the word counters.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  byte source has a byte.
- `s_ready`  out  1  loader accepts a byte; a handshake is `s_valid && s_ready` at a rising edge.
- `s_data`  in  8  stream byte.
- `reload`  in  1  single-cycle request to load a new program; honoured only in DONE or ERR.
- `imem_wr_en`  out  1  instruction memory write strobe, one cycle per word.
- `imem_wr_addr`  out  32  byte address of the word (word index × 4).
- `imem_wr_data`  out  32  assembled instruction word.
- `cpu_resetn`  out  1  active-low reset to the CPU.
- `done`  out  1  program loaded, CPU released.
- `error`  out  1  header word count exceeds `DEPTH`.
- `words_loaded`  out  CNT_W  number of words written so far.

## Operation
- Stream format: a 4-byte header word N (little-endian), then N instruction words, each little-endian; the first byte is bits 7:0.
- States: HDR, DATA, DONE, ERR. The reset state is HDR.
- `s_ready` = 1 in HDR and DATA, 0 in DONE and ERR.
- HDR: accept 4 bytes into N.
  - After the 4th byte: N==0 → DONE; N>DEPTH → ERR; otherwise → DATA.
- DATA: a 2-bit byte index counts accepted bytes.
  - On the 4th byte of a word, register a write: `imem_wr_en`=1, `imem_wr_addr`=`words_loaded`×4, `imem_wr_data`=the assembled word. Increment `words_loaded` at the same edge.
  - When the completed word is the Nth word → DONE.
- DONE: `done`=1. `cpu_resetn`=1 from the edge after DONE is entered.
- ERR: `error`=1 and `cpu_resetn` stays 0.
  - No further writes.
  - ERR is left only via `reload` or `resetn`.
- `reload` in DONE or ERR:
  - → HDR.
  - `cpu_resetn`, `done`, `error`, `words_loaded` and the byte index all go to 0 at that edge.
  - `reload` in HDR or DATA is ignored.
- Cycles with `s_valid`=0 change nothing. Bytes do not need to arrive back to back.
- Memory contents from a previous load are not cleared.

## Timing
- Reset values: state HDR, `cpu_resetn`=0, `imem_wr_en`=0, `imem_wr_addr`=0, `imem_wr_data`=0, `done`=0, `error`=0, `words_loaded`=0, byte index 0, N=0. `s_ready` reads 1 once `resetn` is high.
- All outputs are registered except `s_ready`, which decodes combinationally from state.
- Write latency: `imem_wr_en` is high for exactly the one cycle following the edge that accepted the 4th byte of a word.
- Release: the final byte is accepted at edge k.
  - Edge k: last write strobe, `done`=1.
  - Edge k+1: `cpu_resetn`=1. The write therefore lands before the CPU's first fetch.
  - For N==0 the same timing applies with no write.
- Error: the 4th header byte is accepted at edge k → `error`=1 and `s_ready`=0 from edge k.
- `resetn` asserted mid-load: all state returns to reset values immediately; partial words are discarded. A full new stream is required.
- `words_loaded` saturates at N and never wraps, because N ≤ DEPTH.

## Structure
- Shared package `loader_pkg`: `loader_state_t` enum (HDR, DATA, DONE, ERR) and the `HDR_BYTES`=4 constant.
- Sub-module `word_assembler`: shift-in byte register with a 2-bit index.
  - Inputs: `clk`, `resetn`, `clear`, `byte_valid`, `byte_in`.
  - Outputs: `word_out[31:0]`, `word_valid` (pulsed on the 4th byte).
  - Used for both the header and the instruction words.
- Top level: FSM, counters, and registered memory-write and `cpu_resetn` outputs.

## Test plan
- Program load: stream 02 00 00 00, 13 00 50 00, 93 00 80 00.
  - Writes (0x0, 0x00500013), then (0x4, 0x00800093), one strobe each.
  - `words_loaded`=2.
  - `cpu_resetn` rises one cycle after the last strobe.
- Empty program: stream 00 00 00 00 → no `imem_wr_en`; `done`=1 at the accepting edge; `cpu_resetn`=1 one edge later.
- Oversize: header count DEPTH+1 (01 04 00 00 for DEPTH=1024) → `error`=1, `s_ready`=0, `cpu_resetn` stays 0 for 50 cycles, zero writes.
- Bubbles: the first test's stream with `s_valid` low for 1–3 random cycles between bytes → identical writes and values; no strobe on idle cycles.
- Reload: after the first test, pulse `reload`.
  - Next edge: `cpu_resetn`=0, `done`=0, `words_loaded`=0.
  - Stream 01 00 00 00, 13 05 10 00 → write (0x0, 0x00100513), then release.
- Mid-load reset: assert `resetn` after 6 bytes of the first test's stream.
  - Outputs return to reset values asynchronously.
  - After deassertion, a full stream loads correctly from address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } loader_state_t;

    // Bytes per 32-bit word, for both the header and the instruction words.
    localparam int HDR_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// Gathers little-endian bytes into 32-bit words. The 4th byte is combined
// combinationally with the three held bytes, so the caller can register the
// complete word on the same edge that accepts the final byte.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [1:0]  idx_q;
    logic [23:0] sh_q;

    assign word_valid = byte_valid && (idx_q == 2'(HDR_BYTES - 1));
    assign word_out   = {byte_in, sh_q};

    // Shift accepted bytes in from the top so the first byte ends up in bits 7:0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q <= 2'd0;
            sh_q  <= 24'd0;
        end else if (clear) begin
            idx_q <= 2'd0;
            sh_q  <= 24'd0;
        end else if (byte_valid) begin
            idx_q <= idx_q + 2'd1;
            sh_q  <= {byte_in, sh_q[23:8]};
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: takes a header word N followed by N instruction words from a
// byte stream, writes them to instruction memory, and holds the CPU in reset
// until the last word has been written.
module instr_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             reload,
    output logic             imem_wr_en,
    output logic [31:0]      imem_wr_addr,
    output logic [31:0]      imem_wr_data,
    output logic             cpu_resetn,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    loader_state_t    state_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] words_q, words_d;
    logic [31:0]      addr_d;
    logic             wr_en_q, cpu_resetn_q, done_q, error_q;
    logic [31:0]      wr_addr_q, wr_data_q;

    logic        accept;
    logic        restart;
    logic [31:0] word;
    logic        word_valid;

    assign s_ready = (state_q == HDR) || (state_q == DATA);
    assign accept  = s_valid && s_ready;
    // reload is only meaningful once a load has finished or failed.
    assign restart = reload && ((state_q == DONE) || (state_q == ERR));
    assign words_d = words_q + CNT_W'(1);
    assign addr_d  = 32'(words_q) << 2;

    word_assembler u_asm (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (restart),
        .byte_valid (accept),
        .byte_in    (s_data),
        .word_out   (word),
        .word_valid (word_valid)
    );

    // Loader FSM with registered memory-write, status and CPU reset outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= HDR;
            n_q          <= '0;
            words_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 32'd0;
            wr_data_q    <= 32'd0;
            cpu_resetn_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                HDR: begin
                    if (word_valid) begin
                        if (word == 32'd0) begin
                            n_q     <= '0;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (word > 32'(DEPTH)) begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end else begin
                            n_q     <= word[CNT_W-1:0];
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_d;
                        wr_data_q <= word;
                        words_q   <= words_d;
                        if (words_d == n_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (restart) begin
                        state_q      <= HDR;
                        cpu_resetn_q <= 1'b0;
                        done_q       <= 1'b0;
                        words_q      <= '0;
                    end else begin
                        // Released one edge after entry, so the last write lands first.
                        cpu_resetn_q <= 1'b1;
                    end
                end
                ERR: begin
                    if (restart) begin
                        state_q <= HDR;
                        error_q <= 1'b0;
                        words_q <= '0;
                    end
                end
                default: state_q <= HDR;
            endcase
        end
    end

    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_resetn   = cpu_resetn_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed test-plan streams plus random
// programs, checked against write lists computed directly from the byte stream.
module tb_instr_loader;

    localparam int DEPTH = 1024;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       s_data = 8'd0;
    logic             reload = 1'b0;
    logic             imem_wr_en;
    logic [31:0]      imem_wr_addr, imem_wr_data;
    logic             cpu_resetn, done, error;
    logic [CNT_W-1:0] words_loaded;

    int nvec = 0;
    int nbad = 0;

    logic [7:0]  stream[$];
    logic [63:0] got[$];
    logic [63:0] exp_w[$];

    instr_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .reload       (reload),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_resetn   (cpu_resetn),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen just after a rising edge.
    always @(posedge clk) begin
        #1;
        if (imem_wr_en) got.push_back({imem_wr_addr, imem_wr_data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte after 'gap' idle cycles; returns 1ns after the accepting edge.
    task automatic xfer(input logic [7:0] b, input int gap);
        bit ok = 0;
        repeat (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = 8'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = s_ready;
            @(posedge clk);
            #1;
            if (!ok) @(negedge clk);
        end
        if (!ok) chk("handshake_timeout", 0, 1);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        s_valid = 1'b0;
        reload  = 1'b1;
        @(posedge clk);
        #1;
        chk("reload_cpu_resetn", cpu_resetn, 0);
        chk("reload_done", done, 0);
        chk("reload_error", error, 0);
        chk("reload_words", words_loaded, 0);
        chk("reload_ready", s_ready, 1);
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
    endtask

    // Stream 'stream' into the DUT and compare against the expected outcome.
    task automatic load(input int gmax, input bit mid_reload);
        logic [31:0] n;
        bit          legal;
        int          viol;
        n = {stream[3], stream[2], stream[1], stream[0]};
        legal = (n <= DEPTH);
        exp_w.delete();
        if (legal)
            for (int w = 0; w < int'(n); w++)
                exp_w.push_back({32'(4 * w), stream[4*w+7], stream[4*w+6],
                                 stream[4*w+5], stream[4*w+4]});
        got.delete();
        for (int i = 0; i < stream.size(); i++) begin
            xfer(stream[i], $urandom_range(0, gmax));
            if (i == 3 && !legal) begin
                chk("err_flag", error, 1);
                chk("err_ready", s_ready, 0);
                chk("err_cpu", cpu_resetn, 0);
            end
            if (legal && i == stream.size() - 1) begin
                chk("last_done", done, 1);
                chk("last_cpu_held", cpu_resetn, 0);
                chk("last_strobe", imem_wr_en, (n != 0));
                @(posedge clk);
                #1;
                chk("release_cpu", cpu_resetn, 1);
                chk("release_no_strobe", imem_wr_en, 0);
            end
            if (mid_reload && i == 5) begin
                // Ignored while loading.
                @(negedge clk);
                s_valid = 1'b0;
                reload  = 1'b1;
                @(negedge clk);
                reload  = 1'b0;
            end
        end
        if (!legal) begin
            viol = 0;
            @(negedge clk);
            s_valid = 1'b1;
            for (int c = 0; c < 50; c++) begin
                @(posedge clk);
                #1;
                if (s_ready || cpu_resetn || imem_wr_en || !error) viol++;
            end
            chk("err_hold_50", viol, 0);
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("write_count", got.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got.size(); i++)
            chk($sformatf("write_%0d", i), got[i], exp_w[i]);
        chk("words_loaded", words_loaded, legal ? n[CNT_W-1:0] : '0);
        chk("done_final", done, legal);
        chk("error_final", error, !legal);
        chk("cpu_final", cpu_resetn, legal);
    endtask

    task automatic prog_a();
        stream.delete();
        push_word(32'd2);
        push_word(32'h00500013);
        push_word(32'h00800093);
    endtask

    initial begin
        int nw;
        #23;
        chk("rst_cpu", cpu_resetn, 0);
        chk("rst_wr_en", imem_wr_en, 0);
        chk("rst_addr", imem_wr_addr, 0);
        chk("rst_data", imem_wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_ready", s_ready, 1);

        prog_a();
        load(0, 0);

        pulse_reload();
        stream.delete();
        push_word(32'd1);
        push_word(32'h00100513);
        load(0, 0);

        pulse_reload();
        stream.delete();
        push_word(32'd0);
        load(0, 0);

        pulse_reload();
        prog_a();
        load(3, 1);

        pulse_reload();
        stream.delete();
        push_word(32'(DEPTH + 1));
        load(0, 0);
        pulse_reload();

        // Abort a load with async reset after 6 bytes.
        prog_a();
        for (int i = 0; i < 6; i++) xfer(stream[i], 0);
        @(negedge clk);
        s_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_cpu", cpu_resetn, 0);
        chk("abort_wr_en", imem_wr_en, 0);
        chk("abort_addr", imem_wr_addr, 0);
        chk("abort_data", imem_wr_data, 0);
        chk("abort_done", done, 0);
        chk("abort_words", words_loaded, 0);
        @(negedge clk);
        resetn = 1'b1;
        load(0, 0);

        for (int r = 0; r < 6; r++) begin
            pulse_reload();
            stream.delete();
            nw = $urandom_range(1, 6);
            push_word(32'(nw));
            for (int w = 0; w < nw; w++) push_word($urandom);
            load(2, r[0]);
        end

        pulse_reload();
        stream.delete();
        push_word(32'hFFFF_FFFF);
        load(0, 0);

        pulse_reload();
        stream.delete();
        push_word(32'(DEPTH));
        for (int w = 0; w < DEPTH; w++) push_word($urandom);
        load(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
